iss_ex_hazard_ctrl: RTL and testbench

ISS_EX_HAZARD_CTRL -- requirements
Module: iss_ex_hazard_ctrl

---
 rtl/qtpa_pkg.sv | 9 +
 rtl/iss_ex_hazard_ctrl_if.sv | 29 ++
 rtl/hz_scoreboard.sv | 19 +
 rtl/iss_ex_hazard_ctrl.sv | 94 +++++++++
 tb/tb_iss_ex_hazard_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/qtpa_pkg.sv
// qtpa_pkg: shared types and defaults for the ISS/EX hazard controller.
package qtpa_pkg;
   typedef enum logic [1:0] {RUN, MC_BUSY, FLUSH} hz_state_t;
   localparam int MC_LAT_DEF    = 4;
   localparam int FLUSH_CYC_DEF = 2;
   function automatic logic [15:0] dec16(input logic [3:0] a);
      return 16'h1 << a;
   endfunction
endpackage

// File: rtl/iss_ex_hazard_ctrl_if.sv
// iss_ex_hazard_ctrl_if: pipeline-side signals of the ISS/EX hazard controller.
interface iss_ex_hazard_ctrl_if;
   logic        iss_valid;
   logic [3:0]  iss_rs1_addr;
   logic [3:0]  iss_rs2_addr;
   logic        iss_use_rs1;
   logic        iss_use_rs2;
   logic [3:0]  iss_rd_addr;
   logic        iss_we;
   logic        iss_is_load;
   logic        ex_mc;
   logic [3:0]  wb_rd_addr;
   logic        wb_we;
   logic        redirect;
   logic        iss_stall;
   logic        iss_ex_stall;
   logic        iss_ex_flush;
   logic [15:0] pending;
   modport master (
      output iss_valid, iss_rs1_addr, iss_rs2_addr, iss_use_rs1, iss_use_rs2,
             iss_rd_addr, iss_we, iss_is_load, ex_mc, wb_rd_addr, wb_we, redirect,
      input  iss_stall, iss_ex_stall, iss_ex_flush, pending
   );
   modport slave (
      input  iss_valid, iss_rs1_addr, iss_rs2_addr, iss_use_rs1, iss_use_rs2,
             iss_rd_addr, iss_we, iss_is_load, ex_mc, wb_rd_addr, wb_we, redirect,
      output iss_stall, iss_ex_stall, iss_ex_flush, pending
   );
endinterface

// File: rtl/hz_scoreboard.sv
// hz_scoreboard: 16-entry outstanding-write scoreboard; a set beats a clear of the same bit.
module hz_scoreboard import qtpa_pkg::*; (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        set_en_i,
   input  logic [3:0]  set_addr_i,
   input  logic        clr_en_i,
   input  logic [3:0]  clr_addr_i,
   output logic [15:0] pending_o
);
   logic [15:0] pend_q, pend_d;
   always_comb pend_d = (pend_q & ~(clr_en_i ? dec16(clr_addr_i) : 16'h0))
                      | (set_en_i ? dec16(set_addr_i) : 16'h0);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;
   end
   assign pending_o = pend_q;
endmodule

// File: rtl/iss_ex_hazard_ctrl.sv
// iss_ex_hazard_ctrl: ISS/EX stall/flush control with RAW scoreboard, multi-cycle hold and redirect flush.
// Define QTPA_HAZ_FWD_EN to track only loads and multi-cycle results (ALU results are forwarded).
module iss_ex_hazard_ctrl import qtpa_pkg::*; #(
   parameter int MC_LAT    = MC_LAT_DEF,
   parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
   input logic                 clk,
   input logic                 rst_n,
   iss_ex_hazard_ctrl_if.slave hz
);
   localparam logic [3:0] MC_END = 4'(MC_LAT - 1);
   localparam logic [3:0] FL_END = 4'(FLUSH_CYC);
   hz_state_t   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] pend;
   logic        raw, stall, ex_stall, flush, accept, set_en;
   logic [3:0]  set_addr;
   assign raw = hz.iss_valid & ((hz.iss_use_rs1 & pend[hz.iss_rs1_addr])
                              | (hz.iss_use_rs2 & pend[hz.iss_rs2_addr]));
   // The closing cycle of MC_BUSY/FLUSH behaves like RUN except that ex_mc is not re-armed.
   always_comb begin
      state_d  = RUN;
      cnt_d    = '0;
      stall    = raw;
      ex_stall = 1'b0;
      flush    = raw;
      if (hz.redirect) begin
         stall   = 1'b0;
         flush   = 1'b1;
         state_d = (FLUSH_CYC == 1) ? RUN : FLUSH;
         cnt_d   = (FLUSH_CYC == 1) ? 4'd0 : 4'd1;
      end else if (state_q == MC_BUSY && cnt_q < MC_END) begin
         stall    = 1'b1;
         ex_stall = 1'b1;
         flush    = 1'b0;
         state_d  = MC_BUSY;
         cnt_d    = cnt_q + 4'd1;
      end else if (state_q == FLUSH && cnt_q < FL_END) begin
         stall   = 1'b0;
         flush   = 1'b1;
         state_d = FLUSH;
         cnt_d   = cnt_q + 4'd1;
      end else if (state_q == RUN && hz.ex_mc) begin
         stall    = 1'b1;
         ex_stall = 1'b1;
         flush    = 1'b0;
         state_d  = MC_BUSY;
         cnt_d    = 4'd1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   assign accept = hz.iss_valid & ~stall & ~flush;
`ifdef QTPA_HAZ_FWD_EN
   logic [3:0] ex_rd_q;
   logic       ex_we_q, mc_set;
   // Remember the op now in EX so a multi-cycle result can be tracked once ex_mc reveals it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rd_q <= '0;
         ex_we_q <= 1'b0;
      end else if (!ex_stall) begin
         ex_rd_q <= hz.iss_rd_addr;
         ex_we_q <= accept & hz.iss_we;
      end
   end
   assign mc_set   = (state_q == RUN) & hz.ex_mc & ~hz.redirect & ex_we_q;
   assign set_en   = (accept & hz.iss_we & hz.iss_is_load) | mc_set;
   assign set_addr = mc_set ? ex_rd_q : hz.iss_rd_addr;
`else
   assign set_en   = accept & hz.iss_we;
   assign set_addr = hz.iss_rd_addr;
`endif
   hz_scoreboard u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_en_i   (set_en),
      .set_addr_i (set_addr),
      .clr_en_i   (hz.wb_we),
      .clr_addr_i (hz.wb_rd_addr),
      .pending_o  (pend)
   );
   assign hz.pending      = pend;
   assign hz.iss_stall    = rst_n & stall;
   assign hz.iss_ex_stall = rst_n & ex_stall;
   assign hz.iss_ex_flush = rst_n & flush;
endmodule

// File: tb/tb_iss_ex_hazard_ctrl.sv
// tb_iss_ex_hazard_ctrl: directed bench for iss_ex_hazard_ctrl (MC_LAT=4, FLUSH_CYC=2); builds with or without QTPA_HAZ_FWD_EN.
module tb_iss_ex_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;
   logic [2:0] o;
   iss_ex_hazard_ctrl_if hz();
   iss_ex_hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hz(hz.slave));
   always #5 clk = ~clk;
   assign o = {hz.iss_stall, hz.iss_ex_stall, hz.iss_ex_flush};
   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
   task automatic idle;
      hz.iss_valid = 0; hz.iss_rs1_addr = 0; hz.iss_rs2_addr = 0;
      hz.iss_use_rs1 = 0; hz.iss_use_rs2 = 0; hz.iss_rd_addr = 0;
      hz.iss_we = 0; hz.iss_is_load = 0; hz.ex_mc = 0;
      hz.wb_rd_addr = 0; hz.wb_we = 0; hz.redirect = 0;
   endtask
   task automatic nxt;
      @(posedge clk);
      #1;
      idle();
   endtask
   task automatic load(input logic [3:0] rd);
      hz.iss_valid = 1; hz.iss_we = 1; hz.iss_is_load = 1; hz.iss_rd_addr = rd;
   endtask
   task automatic test_reset;
      idle();
      hz.iss_valid = 1; hz.redirect = 1; hz.ex_mc = 1;
      #3;
      n_run++;
      if (o !== 3'b000) begin n_fail++; $display("FAIL reset_out: got %b want 000", o); end
      n_run++;
      if (hz.pending !== 16'h0) begin n_fail++; $display("FAIL reset_pend: got %h want 0000", hz.pending); end
      idle();
      @(negedge clk);
      rst_n = 1;
   endtask
   task automatic test_raw_load;
      nxt(); load(4'd3); #3;
      n_run++;
      if (o !== 3'b000) begin n_fail++; $display("FAIL raw_accept: got %b want 000", o); end
      for (int i = 0; i < 2; i++) begin
         nxt(); hz.iss_valid = 1; hz.iss_rs1_addr = 3; hz.iss_use_rs1 = 1;
         hz.wb_we = (i == 1); hz.wb_rd_addr = 3; #3;
         n_run++;
         if (o !== 3'b101) begin n_fail++; $display("FAIL raw_stall%0d: got %b want 101", i, o); end
         n_run++;
         if (hz.pending !== 16'h0008) begin n_fail++; $display("FAIL raw_pend%0d: got %h want 0008", i, hz.pending); end
      end
      nxt(); hz.iss_valid = 1; hz.iss_rs1_addr = 3; hz.iss_use_rs1 = 1; #3;
      n_run++;
      if (o !== 3'b000) begin n_fail++; $display("FAIL raw_release: got %b want 000", o); end
      n_run++;
      if (hz.pending !== 16'h0) begin n_fail++; $display("FAIL raw_clear: got %h want 0000", hz.pending); end
   endtask
   task automatic test_alu_fwd;
      logic [2:0]  exp_o;
      logic [15:0] exp_p;
`ifdef QTPA_HAZ_FWD_EN
      exp_o = 3'b000; exp_p = 16'h0000;
`else
      exp_o = 3'b101; exp_p = 16'h0080;
`endif
      nxt(); hz.iss_valid = 1; hz.iss_we = 1; hz.iss_rd_addr = 7; #3;
      nxt(); hz.iss_valid = 1; hz.iss_rs2_addr = 7; hz.iss_use_rs2 = 1; #3;
      n_run++;
      if (o !== exp_o) begin n_fail++; $display("FAIL alu_read: got %b want %b", o, exp_o); end
      n_run++;
      if (hz.pending !== exp_p) begin n_fail++; $display("FAIL alu_pend: got %h want %h", hz.pending, exp_p); end
      nxt(); hz.wb_we = 1; hz.wb_rd_addr = 7;
      nxt(); #3;
      n_run++;
      if (hz.pending !== 16'h0) begin n_fail++; $display("FAIL alu_clear: got %h want 0000", hz.pending); end
   endtask
   task automatic test_same_cycle;
      nxt(); load(4'd5); #3;
      nxt(); load(4'd5); hz.wb_we = 1; hz.wb_rd_addr = 5; #3;
      n_run++;
      if (o !== 3'b000) begin n_fail++; $display("FAIL same_accept: got %b want 000", o); end
      nxt(); #3;
      n_run++;
      if (hz.pending !== 16'h0020) begin n_fail++; $display("FAIL same_set_wins: got %h want 0020", hz.pending); end
      nxt(); hz.wb_we = 1; hz.wb_rd_addr = 5;
      nxt(); #3;
      n_run++;
      if (hz.pending !== 16'h0) begin n_fail++; $display("FAIL same_clear: got %h want 0000", hz.pending); end
   endtask
   task automatic test_mc;
      for (int i = 0; i < 4; i++) begin
         nxt(); hz.ex_mc = 1; load(4'd9); #3;
         n_run++;
         if (o !== (i < 3 ? 3'b110 : 3'b000)) begin n_fail++; $display("FAIL mc_cyc%0d: got %b want %b", i, o, (i < 3 ? 3'b110 : 3'b000)); end
      end
      n_run++;
      if (hz.pending !== 16'h0) begin n_fail++; $display("FAIL mc_no_early_accept: got %h want 0000", hz.pending); end
      nxt(); #3;
      n_run++;
      if (o !== 3'b000) begin n_fail++; $display("FAIL mc_after: got %b want 000", o); end
      n_run++;
      if (hz.pending !== 16'h0200) begin n_fail++; $display("FAIL mc_accept: got %h want 0200", hz.pending); end
      nxt(); hz.wb_we = 1; hz.wb_rd_addr = 9;
   endtask
   task automatic test_redirect_mc;
      logic [2:0] exp [4] = '{3'b110, 3'b001, 3'b001, 3'b000};
      for (int i = 0; i < 4; i++) begin
         nxt(); load(4'd10); hz.ex_mc = (i < 2); hz.redirect = (i == 1); #3;
         n_run++;
         if (o !== exp[i]) begin n_fail++; $display("FAIL redir_mc%0d: got %b want %b", i, o, exp[i]); end
      end
      n_run++;
      if (hz.pending !== 16'h0) begin n_fail++; $display("FAIL redir_no_accept: got %h want 0000", hz.pending); end
      nxt(); #3;
      n_run++;
      if (hz.pending !== 16'h0400) begin n_fail++; $display("FAIL redir_accept: got %h want 0400", hz.pending); end
      nxt(); hz.wb_we = 1; hz.wb_rd_addr = 10;
   endtask
   task automatic test_redirect_restart;
      logic [2:0] exp [4] = '{3'b001, 3'b001, 3'b001, 3'b000};
      for (int i = 0; i < 4; i++) begin
         nxt(); hz.redirect = (i < 2); #3;
         n_run++;
         if (o !== exp[i]) begin n_fail++; $display("FAIL restart%0d: got %b want %b", i, o, exp[i]); end
      end
   endtask
   task automatic test_priority;
      logic [2:0] exp [5] = '{3'b110, 3'b001, 3'b001, 3'b101, 3'b101};
      nxt(); load(4'd12); #3;
      for (int i = 0; i < 5; i++) begin
         nxt(); hz.iss_valid = 1; hz.iss_rs1_addr = 12; hz.iss_use_rs1 = 1;
         hz.ex_mc = (i == 0); hz.redirect = (i == 1);
         hz.wb_we = (i == 4); hz.wb_rd_addr = 12; #3;
         n_run++;
         if (o !== exp[i]) begin n_fail++; $display("FAIL prio%0d: got %b want %b", i, o, exp[i]); end
      end
      nxt(); hz.iss_valid = 1; hz.iss_rs1_addr = 12; hz.iss_use_rs1 = 1; #3;
      n_run++;
      if (o !== 3'b000) begin n_fail++; $display("FAIL prio_release: got %b want 000", o); end
   endtask
   task automatic test_reset_mid_mc;
      nxt(); load(4'd14); #3;
      nxt(); hz.ex_mc = 1; #3;
      nxt(); hz.ex_mc = 1; hz.iss_valid = 1; hz.iss_rs1_addr = 14; hz.iss_use_rs1 = 1; #3;
      n_run++;
      if (o !== 3'b110) begin n_fail++; $display("FAIL rst_pre: got %b want 110", o); end
      rst_n = 0; hz.redirect = 1;
      #1;
      n_run++;
      if (o !== 3'b000) begin n_fail++; $display("FAIL rst_async_out: got %b want 000", o); end
      n_run++;
      if (hz.pending !== 16'h0) begin n_fail++; $display("FAIL rst_async_pend: got %h want 0000", hz.pending); end
      #2;
      rst_n = 1; hz.redirect = 0; hz.ex_mc = 0;
      nxt(); hz.iss_valid = 1; hz.iss_rs1_addr = 14; hz.iss_use_rs1 = 1; #3;
      n_run++;
      if (o !== 3'b000) begin n_fail++; $display("FAIL rst_run: got %b want 000", o); end
   endtask
   initial begin
      test_reset();
      test_raw_load();
      test_alu_fwd();
      test_same_cycle();
      test_mc();
      test_redirect_mc();
      test_redirect_restart();
      test_priority();
      test_reset_mid_mc();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
